ucode_fetch: RTL and testbench
==============================

# ucode_fetch

Microinstruction fetch stage of the micro-BESM CPU. It drives a synchronous 4096-entry microcode ROM and presents the execution-stage microinstruction (`o_pc_x`, `o_opcode_x`) to the control/datapath. It also presents the fetch-stage address (`o_pc_f`) that the trace monitor samples. It supports stall, zero-bubble redirect (jump), halt, and a retired-microinstruction counter.

## Interface
- `AW`, 12, microcode address width (4096 words).
- `DW`, 112, microinstruction width.
- `CW`, 32, retired-instruction counter width.

- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset: 0 resets the block immediately, whatever the clock is doing.
- `i_stall`  in  1  hold the execution stage. The current microinstruction repeats.
- `i_jump`  in  1  redirect request, taken this edge.
- `i_jump_addr`  in  AW  redirect target.
- `i_halt`  in  1  enter HALT.
- `o_rom_addr`  out  AW  ROM read address.
- `o_rom_en`  out  1  ROM read enable. The ROM captures `o_rom_addr` on the edge when this is 1, and its output holds when this is 0.
- `i_rom_data`  in  DW  ROM registered output.
- `o_pc_f`  out  AW  address of the next sequential fetch.
- `o_pc_x`  out  AW  address of the microinstruction at execution.
- `o_opcode_x`  out  DW  microinstruction at execution. It is all-zero when `o_valid_x`=0.
- `o_valid_x`  out  1  execution stage holds a real microinstruction.
- `o_state`  out  2  00=IDLE, 01=RUN, 10=HALT.
- `o_icount`  out  CW  retired count, saturating.

## Operation
- **State registers:** `pc_f`, `pc_x`, `valid_x`, `state`, `icount`.
- **Output wiring:**
  - `o_opcode_x` = `valid_x` ? `i_rom_data` : 0.
  - `o_rom_addr` = `i_jump` ? `i_jump_addr` : `pc_f` (combinational).
  - `o_rom_en` = `i_jump` | (state != HALT & ~`i_stall`) | state == IDLE.
- **Per-edge action priority:** jump > halt > stall > advance.
  - **Jump** (any state): `pc_x`←`i_jump_addr`, `pc_f`←`i_jump_addr`+1, `valid_x`←1, state←RUN, `icount`+1. Adds zero bubbles: the target opcode is on `o_opcode_x` in the next cycle.
  - **Halt** (RUN, no jump): state←HALT, `valid_x`←0, `pc_f` and `pc_x` hold, and the count is not incremented.
  - **Stall** (RUN, no jump/halt): all registers hold. The ROM is disabled, so `i_rom_data` and `o_opcode_x` hold.
  - **Advance** (RUN): `pc_x`←`pc_f`, `pc_f`←`pc_f`+1, `valid_x`←1, `icount`+1.
- **IDLE:**
  - The block is in IDLE after reset. The ROM is enabled with `o_rom_addr`=0, or the jump target if `i_jump`=1.
  - On the first edge after reset release it advances unconditionally (`i_stall` and `i_halt` are ignored): `pc_x`←0, `pc_f`←1, `valid_x`←1, state←RUN.
  - A jump in IDLE takes the jump path instead.
- **HALT:** all registers hold and `o_rom_en`=0. Only `i_jump` exits. `i_stall` and `i_halt` are ignored.
- **Arithmetic:** `pc_f`+1 and `i_jump_addr`+1 wrap modulo 2^AW (4095→0).
- **Counter:** `icount` saturates at 2^CW−1 and never wraps.

## Timing
- **Reset values (asynchronous):** `pc_f`=0, `pc_x`=0, `valid_x`=0, `o_opcode_x`=0, state=IDLE, `icount`=0.
  - During reset, `o_rom_addr` = `i_jump` ? `i_jump_addr` : 0.
  - During reset, `o_rom_en`=1.
- **Latency:**
  - The ROM word at address A appears on `o_opcode_x` in the cycle after the edge that fetched A.
  - The first valid opcode (address 0) appears one cycle after the first post-reset edge.
- **Stall:** a stall asserted for N cycles holds `o_pc_x` and `o_opcode_x` for N additional cycles, with no count increment.
- **Jump coincident with stall or halt:** jump wins. The stall or halt is ignored that edge.
- **Jump in HALT:** the target is executing in the next cycle (`valid_x`=1).
- **Reset mid-run (asynchronous):** outputs return to reset values immediately, without waiting for a clock edge. Fetch restarts from address 0.
- `o_pc_f` always equals `o_pc_x`+1 (mod 4096) while state is RUN.

## Test plan
- **Reset release:** ROM[k]=k, no stall. After 4 edges → `o_pc_x` sequence 0,1,2,3, `o_opcode_x`=`o_pc_x`, `o_icount`=4, `o_pc_f`=4.
- **Stall:** stall for 3 cycles while `o_pc_x`=5 → `o_pc_x`=5 and `o_opcode_x`=ROM[5] for 4 cycles. Next advance gives 6. `o_icount` rises by 1 across the stall.
- **Jump:** jump to 1286 with `i_stall`=1 on the same edge → next cycle `o_pc_x`=1286, `o_opcode_x`=ROM[1286], `o_pc_f`=1287. No zero-opcode cycle.
- **Wrap:** jump to 4094, then advance twice → `o_pc_x` 4094, 4095, 0; `o_pc_f` 4095, 0, 1.
- **Halt:** halt while `o_pc_x`=20 → `o_valid_x`=0, `o_opcode_x`=0, `o_rom_en`=0, `o_icount` frozen. Stall/halt toggling has no effect. Jump to 100 → `o_pc_x`=100, state RUN.
- **Reset edge cases:**
  - Reset asserted mid-cycle with `o_pc_x`=300 → all outputs at reset values before the next clock edge.
  - Counter preloaded to 2^32−2 via force: two advances → `o_icount` holds at FFFFFFFF.

Source files
------------

// File: rtl/ucode_fetch_if.sv
// Fetch-stage bus: control inputs, ROM port and execution-stage outputs.
interface ucode_fetch_if #(
  parameter int AW = 12,
  parameter int DW = 112,
  parameter int CW = 32
);
  logic          i_stall;
  logic          i_jump;
  logic [AW-1:0] i_jump_addr;
  logic          i_halt;
  logic [AW-1:0] o_rom_addr;
  logic          o_rom_en;
  logic [DW-1:0] i_rom_data;
  logic [AW-1:0] o_pc_f;
  logic [AW-1:0] o_pc_x;
  logic [DW-1:0] o_opcode_x;
  logic          o_valid_x;
  logic [1:0]    o_state;
  logic [CW-1:0] o_icount;

  modport master (
    output i_stall, i_jump, i_jump_addr, i_halt, i_rom_data,
    input  o_rom_addr, o_rom_en, o_pc_f, o_pc_x, o_opcode_x, o_valid_x, o_state, o_icount
  );

  modport slave (
    input  i_stall, i_jump, i_jump_addr, i_halt, i_rom_data,
    output o_rom_addr, o_rom_en, o_pc_f, o_pc_x, o_opcode_x, o_valid_x, o_state, o_icount
  );
endinterface

// File: rtl/ucode_fetch.sv
// Microinstruction fetch stage: drives a registered microcode ROM and tracks
// the execution-stage PC with stall, zero-bubble jump, halt and a retire count.
module ucode_fetch #(
  parameter int AW = 12,
  parameter int DW = 112,
  parameter int CW = 32
) (
  input  logic           clk,
  input  logic           reset,
  ucode_fetch_if.slave   fif
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_f_q, pc_f_d;
  logic [AW-1:0] pc_x_q, pc_x_d;
  logic          valid_x_q, valid_x_d;
  logic [CW-1:0] icount_q, icount_d;
  logic          retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_f_q    <= '0;
      pc_x_q    <= '0;
      valid_x_q <= 1'b0;
      icount_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_f_q    <= pc_f_d;
      pc_x_q    <= pc_x_d;
      valid_x_q <= valid_x_d;
      icount_q  <= icount_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_f_d    = pc_f_q;
    pc_x_d    = pc_x_q;
    valid_x_d = valid_x_q;
    retire    = 1'b0;
    if (fif.i_jump) begin
      // ROM is already reading the target this edge, so no bubble is needed
      pc_x_d    = fif.i_jump_addr;
      pc_f_d    = fif.i_jump_addr + AW'(1);
      valid_x_d = 1'b1;
      state_d   = RUN;
      retire    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          pc_x_d    = '0;
          pc_f_d    = AW'(1);
          valid_x_d = 1'b1;
          state_d   = RUN;
          retire    = 1'b1;
        end
        RUN: begin
          if (fif.i_halt) begin
            state_d   = HALT;
            valid_x_d = 1'b0;
          end else if (!fif.i_stall) begin
            pc_x_d    = pc_f_q;
            pc_f_d    = pc_f_q + AW'(1);
            valid_x_d = 1'b1;
            retire    = 1'b1;
          end
        end
        default: ;
      endcase
    end
    icount_d = (retire && icount_q != {CW{1'b1}}) ? icount_q + CW'(1) : icount_q;
  end

  // ROM output holds whenever the enable is low, which is how stall keeps the opcode
  assign fif.o_rom_en   = fif.i_jump | ((state_q != HALT) & ~fif.i_stall) | (state_q == IDLE);
  assign fif.o_rom_addr = fif.i_jump ? fif.i_jump_addr : pc_f_q;
  assign fif.o_opcode_x = valid_x_q ? fif.i_rom_data : '0;
  assign fif.o_pc_f     = pc_f_q;
  assign fif.o_pc_x     = pc_x_q;
  assign fif.o_valid_x  = valid_x_q;
  assign fif.o_state    = state_q;
  assign fif.o_icount   = icount_q;

endmodule

// File: tb/tb_ucode_fetch.sv
// Directed bench for ucode_fetch with a registered ROM model where ROM[k]=k.
module tb_ucode_fetch;
  localparam int AW = 12;
  localparam int DW = 112;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  ucode_fetch_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

  ucode_fetch #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .fif   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom_q;
  always @(posedge clk) if (bus.o_rom_en) rom_q <= DW'(bus.o_rom_addr);
  assign bus.i_rom_data = rom_q;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_x(input string tag, input int pc, input int icnt);
    chk({tag, " pc_x"}, 128'(bus.o_pc_x), 128'(pc));
    chk({tag, " opcode"}, 128'(bus.o_opcode_x), 128'(pc));
    chk({tag, " valid"}, 128'(bus.o_valid_x), 128'(1));
    chk({tag, " icount"}, 128'(bus.o_icount), 128'(icnt));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " pc_f"}, 128'(bus.o_pc_f), 128'(0));
    chk({tag, " pc_x"}, 128'(bus.o_pc_x), 128'(0));
    chk({tag, " valid"}, 128'(bus.o_valid_x), 128'(0));
    chk({tag, " opcode"}, 128'(bus.o_opcode_x), 128'(0));
    chk({tag, " state"}, 128'(bus.o_state), 128'(0));
    chk({tag, " icount"}, 128'(bus.o_icount), 128'(0));
    chk({tag, " rom_en"}, 128'(bus.o_rom_en), 128'(1));
    chk({tag, " rom_addr"}, 128'(bus.o_rom_addr), 128'(0));
  endtask

  initial begin
    bus.i_stall = 1'b0;
    bus.i_jump = 1'b0;
    bus.i_jump_addr = '0;
    bus.i_halt = 1'b0;

    // reset state, and jump target visible on the ROM address during reset
    #2;
    chk_reset("rst");
    bus.i_jump = 1'b1;
    bus.i_jump_addr = 12'd77;
    #1;
    chk("rst jaddr", 128'(bus.o_rom_addr), 128'(77));
    bus.i_jump = 1'b0;
    edge1();
    reset = 1'b1;
    chk("idle state", 128'(bus.o_state), 128'(0));

    // reset release: 0,1,2,3
    for (int k = 0; k < 4; k++) begin
      edge1();
      chk_x("seq", k, k + 1);
    end
    chk("seq pc_f", 128'(bus.o_pc_f), 128'(4));
    chk("seq state", 128'(bus.o_state), 128'(1));
    edge1();
    edge1();
    chk_x("pre stall", 5, 6);

    // stall 3 cycles at pc_x=5
    bus.i_stall = 1'b1;
    #1;
    chk("stall rom_en", 128'(bus.o_rom_en), 128'(0));
    for (int k = 0; k < 3; k++) begin
      edge1();
      chk_x("stall", 5, 6);
    end
    bus.i_stall = 1'b0;
    edge1();
    chk_x("post stall", 6, 7);
    chk("post stall pc_f", 128'(bus.o_pc_f), 128'(7));

    // jump coincident with stall
    bus.i_jump = 1'b1;
    bus.i_jump_addr = 12'd1286;
    bus.i_stall = 1'b1;
    #1;
    chk("jump rom_en", 128'(bus.o_rom_en), 128'(1));
    chk("jump rom_addr", 128'(bus.o_rom_addr), 128'(1286));
    edge1();
    bus.i_jump = 1'b0;
    bus.i_stall = 1'b0;
    chk_x("jump", 1286, 8);
    chk("jump pc_f", 128'(bus.o_pc_f), 128'(1287));

    // wrap
    bus.i_jump = 1'b1;
    bus.i_jump_addr = 12'd4094;
    edge1();
    bus.i_jump = 1'b0;
    chk_x("wrap0", 4094, 9);
    chk("wrap0 pc_f", 128'(bus.o_pc_f), 128'(4095));
    edge1();
    chk_x("wrap1", 4095, 10);
    chk("wrap1 pc_f", 128'(bus.o_pc_f), 128'(0));
    edge1();
    chk_x("wrap2", 0, 11);
    chk("wrap2 pc_f", 128'(bus.o_pc_f), 128'(1));

    // halt at pc_x=20
    bus.i_jump = 1'b1;
    bus.i_jump_addr = 12'd20;
    edge1();
    bus.i_jump = 1'b0;
    chk_x("pre halt", 20, 12);
    bus.i_halt = 1'b1;
    edge1();
    chk("halt state", 128'(bus.o_state), 128'(2));
    chk("halt valid", 128'(bus.o_valid_x), 128'(0));
    chk("halt opcode", 128'(bus.o_opcode_x), 128'(0));
    chk("halt rom_en", 128'(bus.o_rom_en), 128'(0));
    chk("halt icount", 128'(bus.o_icount), 128'(12));
    bus.i_halt = 1'b0;
    bus.i_stall = 1'b1;
    edge1();
    bus.i_stall = 1'b0;
    #1;
    chk("halt rom_en2", 128'(bus.o_rom_en), 128'(0));
    edge1();
    chk("halt hold state", 128'(bus.o_state), 128'(2));
    chk("halt hold pc_x", 128'(bus.o_pc_x), 128'(20));
    chk("halt hold pc_f", 128'(bus.o_pc_f), 128'(21));
    chk("halt hold icount", 128'(bus.o_icount), 128'(12));
    chk("halt hold valid", 128'(bus.o_valid_x), 128'(0));
    bus.i_jump = 1'b1;
    bus.i_jump_addr = 12'd100;
    edge1();
    bus.i_jump = 1'b0;
    chk_x("halt exit", 100, 13);
    chk("halt exit state", 128'(bus.o_state), 128'(1));

    // asynchronous reset mid-cycle at pc_x=300
    bus.i_jump = 1'b1;
    bus.i_jump_addr = 12'd300;
    edge1();
    bus.i_jump = 1'b0;
    chk_x("pre mid rst", 300, 14);
    #2;
    reset = 1'b0;
    #1;
    chk_reset("mid rst");
    edge1();
    reset = 1'b1;
    edge1();
    chk_x("restart0", 0, 1);
    edge1();
    chk_x("restart1", 1, 2);

    // counter saturation
    force dut.icount_q = 32'hFFFF_FFFE;
    #1;
    release dut.icount_q;
    #1;
    chk("sat preload", 128'(bus.o_icount), 128'(32'hFFFF_FFFE));
    edge1();
    chk("sat1", 128'(bus.o_icount), 128'(32'hFFFF_FFFF));
    edge1();
    chk("sat2", 128'(bus.o_icount), 128'(32'hFFFF_FFFF));
    chk("sat pc_x", 128'(bus.o_pc_x), 128'(3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
